// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for a 256x8 single-port data memory (IDLE -> SERVE -> ACK).
// Define DATA_MEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module data_mem_arbiter (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       we0,
  input  logic       we1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       owner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;

  logic       tieWinner;
  logic       winner;
  logic       serving;
  logic [7:0] selAddr;
  logic [7:0] selWdata;
  logic       selWe;

`ifdef DATA_MEM_ARB_RR_EN
  assign tieWinner = ~owner_q;
`else
  assign tieWinner = 1'b0;
`endif

  // A lone requester always wins; only a tie consults the configured policy.
  assign winner = (req0 && req1) ? tieWinner : req1;

  assign serving  = (state_q == ST_SERVE);
  assign selAddr  = owner_q ? addr1  : addr0;
  assign selWdata = owner_q ? wdata1 : wdata0;
  assign selWe    = owner_q ? we1    : we0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read data is captured on the SERVE->ACK edge; writes leave the port's rdata alone.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (serving && !selWe) begin
      if (owner_q) rdata1_d = mem_rdata;
      else         rdata0_d = mem_rdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b1;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory strobes derive only from the state, so an async reset kills mem_we at once.
  assign mem_addr  = serving ? selAddr  : 8'h00;
  assign mem_wdata = serving ? selWdata : 8'h00;
  assign mem_we    = serving & selWe;

  assign ack0   = (state_q == ST_ACK) & ~owner_q;
  assign ack1   = (state_q == ST_ACK) &  owner_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != ST_IDLE);
  assign owner  = owner_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: memory model, transaction-level reference model,
// directed scenarios and a randomized phase, all checked from one process.
module tb_data_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       busy, owner;

  logic       loadEn = 1'b0;
  logic [7:0] loadAddr = 8'h00;
  logic [7:0] loadData = 8'h00;

  int totalCount = 0;
  int badCount = 0;
  int weCount = 0;

  data_mem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // The physical 256x8 memory the arbiter drives.
  logic [7:0] memArray [256];
  bit memInit = 1'b0;
  assign mem_rdata = memArray[mem_addr];

  always @(posedge CLK) begin
    if (!memInit) begin
      for (int i = 0; i < 256; i++) memArray[i] <= pat(i);
      memInit <= 1'b1;
    end else if (loadEn) memArray[loadAddr] <= loadData;
    else if (mem_we) memArray[mem_addr] <= mem_wdata;
  end

  // Reference model: one transaction at a time, tracked by its age since grant.
  logic [7:0] modelMem [256];
  bit         modelInit = 1'b0;
  bit         mActive = 1'b0;
  int         mAge = 0;
  bit         mPort = 1'b0;
  bit         mOwner = 1'b1;
  logic [7:0] mRdata0 = 8'h00, mRdata1 = 8'h00;

  always @(posedge CLK) begin
    if (!modelInit) begin
      for (int i = 0; i < 256; i++) modelMem[i] = pat(i);
      modelInit = 1'b1;
    end
    if (loadEn) modelMem[loadAddr] = loadData;
    if (!RST_N) begin
      mActive = 1'b0; mAge = 0; mOwner = 1'b1; mRdata0 = 8'h00; mRdata1 = 8'h00;
    end else if (mActive && mAge == 1) begin
      if (mPort ? we1 : we0) modelMem[mPort ? addr1 : addr0] = mPort ? wdata1 : wdata0;
      else if (mPort) mRdata1 = modelMem[addr1];
      else mRdata0 = modelMem[addr0];
      mAge = 2;
    end else if (mActive) begin
      mActive = 1'b0; mAge = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) begin
`ifdef DATA_MEM_ARB_RR_EN
        mPort = ~mOwner;
`else
        mPort = 1'b0;
`endif
      end else mPort = req1;
      mOwner = mPort; mActive = 1'b1; mAge = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    logic eServe, eAck, eWe;
    logic [7:0] eAddr, eWdata;
    eServe = mActive && (mAge == 1);
    eAck   = mActive && (mAge == 2);
    eWe    = eServe && (mPort ? we1 : we0);
    eAddr  = eServe ? (mPort ? addr1 : addr0) : 8'h00;
    eWdata = eServe ? (mPort ? wdata1 : wdata0) : 8'h00;
    checkOutput("ack0", 8'(ack0), 8'(eAck && !mPort));
    checkOutput("ack1", 8'(ack1), 8'(eAck && mPort));
    checkOutput("rdata0", rdata0, mRdata0);
    checkOutput("rdata1", rdata1, mRdata1);
    checkOutput("mem_addr", mem_addr, eAddr);
    checkOutput("mem_wdata", mem_wdata, eWdata);
    checkOutput("mem_we", 8'(mem_we), 8'(eWe));
    checkOutput("busy", 8'(busy), 8'(mActive));
    checkOutput("owner", 8'(owner), 8'(mOwner));
    if (mem_we) weCount++;
  endtask

  task automatic tick();
    @(negedge CLK);
    compareModel();
  endtask

  task automatic loadMem(input logic [7:0] a, input logic [7:0] d);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    tick();
    loadEn = 1'b0;
  endtask

  // Random requesters that obey the hold-until-ack protocol.
  task automatic applyStimulus();
    if (!req0) begin
      if ($urandom_range(0, 2) == 0) begin
        req0 = 1'b1; addr0 = 8'($urandom_range(0, 15));
        we0 = ($urandom_range(0, 1) == 1); wdata0 = 8'($urandom);
      end
    end else if (mActive && mAge == 2 && !mPort) begin
      if ($urandom_range(0, 1) == 0) req0 = 1'b0;
      else begin
        addr0 = 8'($urandom_range(0, 15)); we0 = ($urandom_range(0, 1) == 1); wdata0 = 8'($urandom);
      end
    end else if (mActive && mAge == 1 && !mPort && $urandom_range(0, 9) == 0) req0 = 1'b0;

    if (!req1) begin
      if ($urandom_range(0, 2) == 0) begin
        req1 = 1'b1; addr1 = 8'($urandom_range(0, 15));
        we1 = ($urandom_range(0, 1) == 1); wdata1 = 8'($urandom);
      end
    end else if (mActive && mAge == 2 && mPort) begin
      if ($urandom_range(0, 1) == 0) req1 = 1'b0;
      else begin
        addr1 = 8'($urandom_range(0, 15)); we1 = ($urandom_range(0, 1) == 1); wdata1 = 8'($urandom);
      end
    end else if (mActive && mAge == 1 && mPort && $urandom_range(0, 9) == 0) req1 = 1'b0;
  endtask

  initial begin
    int ackSeq[$];
    int weBefore;
    int waited;

    tick(); tick();
    checkOutput("rstAck0", 8'(ack0), 8'd0);
    checkOutput("rstAck1", 8'(ack1), 8'd0);
    checkOutput("rstRdata0", rdata0, 8'h00);
    checkOutput("rstRdata1", rdata1, 8'h00);
    checkOutput("rstMemAddr", mem_addr, 8'h00);
    checkOutput("rstMemWe", 8'(mem_we), 8'd0);
    checkOutput("rstBusy", 8'(busy), 8'd0);
    checkOutput("rstOwner", 8'(owner), 8'd1);
    RST_N = 1'b1;
    tick();

    // Single read on port 1
    loadMem(8'h10, 8'h5A);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    tick();
    checkOutput("rdServeBusy", 8'(busy), 8'd1);
    checkOutput("rdServeAddr", mem_addr, 8'h10);
    checkOutput("rdServeAck1", 8'(ack1), 8'd0);
    tick();
    checkOutput("rdAck1", 8'(ack1), 8'd1);
    checkOutput("rdData1", rdata1, 8'h5A);
    checkOutput("rdAck0", 8'(ack0), 8'd0);
    checkOutput("rdData0", rdata0, 8'h00);
    req1 = 1'b0;
    tick();
    checkOutput("rdIdle", 8'(busy), 8'd0);

    // Write then read on port 0
    weBefore = weCount;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h2B; wdata0 = 8'h33;
    tick();
    checkOutput("wrServeWe", 8'(mem_we), 8'd1);
    checkOutput("wrServeAddr", mem_addr, 8'h2B);
    checkOutput("wrServeData", mem_wdata, 8'h33);
    tick();
    checkOutput("wrAck0", 8'(ack0), 8'd1);
    checkOutput("wrAckWe", 8'(mem_we), 8'd0);
    we0 = 1'b0; wdata0 = 8'h00;
    tick();
    checkOutput("wrIdleBusy", 8'(busy), 8'd0);
    tick();
    tick();
    checkOutput("rbAck0", 8'(ack0), 8'd1);
    checkOutput("rbData0", rdata0, 8'h33);
    req0 = 1'b0;
    tick();
    checkOutput("wrWeCycles", 8'(weCount - weBefore), 8'd1);

    // Both ports requesting continuously from reset
    RST_N = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 8'h10; addr1 = 8'h2B;
    tick();
    RST_N = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack0) ackSeq.push_back(0);
      if (ack1) ackSeq.push_back(1);
    end
    checkOutput("tieAckCount", 8'(ackSeq.size()), 8'd4);
    if (ackSeq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef DATA_MEM_ARB_RR_EN
        checkOutput("tieOrder", 8'(ackSeq[i]), 8'(i % 2));
`else
        checkOutput("tieOrder", 8'(ackSeq[i]), 8'd0);
`endif
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset during a port-1 write
    loadMem(8'h05, 8'h11);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h05; wdata1 = 8'hFF;
    tick();
    checkOutput("midServeWe", 8'(mem_we), 8'd1);
    RST_N = 1'b0; req1 = 1'b0; we1 = 1'b0;
    #1;
    checkOutput("midWe", 8'(mem_we), 8'd0);
    checkOutput("midBusy", 8'(busy), 8'd0);
    checkOutput("midOwner", 8'(owner), 8'd1);
    checkOutput("midAck1", 8'(ack1), 8'd0);
    checkOutput("midAddr", mem_addr, 8'h00);
    checkOutput("midRdata0", rdata0, 8'h00);
    checkOutput("midRdata1", rdata1, 8'h00);
    tick();
    checkOutput("midNoWrite", memArray[8'h05], 8'h11);
    RST_N = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h2B;
    tick();
    checkOutput("postRstOwner", 8'(owner), 8'd0);
    tick();
    checkOutput("postRstAck0", 8'(ack0), 8'd1);
    checkOutput("postRstAck1", 8'(ack1), 8'd0);
    req0 = 1'b0;
    tick(); tick(); tick();
    checkOutput("postRstAck1b", 8'(ack1), 8'd1);
    checkOutput("postRstData1", rdata1, 8'h33);
    req1 = 1'b0;
    tick();

    // Request dropped during SERVE
    loadMem(8'h00, 8'h77);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    tick();
    req0 = 1'b0;
    tick();
    checkOutput("dropAck0", 8'(ack0), 8'd1);
    checkOutput("dropData0", rdata0, 8'h77);
    tick();
    checkOutput("dropIdle", 8'(busy), 8'd0);
    tick();
    checkOutput("dropStayIdle", 8'(busy), 8'd0);

    // Back-to-back reads on port 1
    for (int i = 1; i <= 4; i++) loadMem(8'(i), 8'(8'h40 + i));
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h01;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!ack1 && waited < 10);
      checkOutput("b2bAck", 8'(ack1), 8'd1);
      checkOutput("b2bData", rdata1, 8'(8'h41 + k));
      checkOutput("b2bNoAck0", 8'(ack0), 8'd0);
      checkOutput("b2bGap", 8'(waited), (k == 0) ? 8'd2 : 8'd3);
      addr1 = 8'(k + 2);
    end
    req1 = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      applyStimulus();
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    for (int i = 0; i < 256; i++) checkOutput("memImage", memArray[i], modelMem[i]);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
